pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register between two CPU stages (IF/ID, ID/EX, ...).
//  Carries a DW-bit payload with a valid/ready handshake and an optional 2-entry skid buffer.
//  Supports stage stall, control flush to bubble (NOP_VAL) and a saturating flushed-beat counter.
// PARAMETERS
//  DW      64     payload width in bits ({instr,pc4} for IF/ID)
//  NOP_VAL 0      payload driven on out_data whenever no valid entry is held
//  SKID    1      1: 2-entry buffer, registered in_ready; 0: single entry, pass-through ready
//  CW      8      width of flush_cnt
// PORTS
//  clk        in   1    clock, rising edge
//  clr        in   1    reset, asynchronous, active-high
//  flush      in   1    sync flush (branch/jump taken): drop all held and incoming beats
//  stall      in   1    sync freeze (load-use hazard): no accept, no emit
//  in_valid   in   1    upstream beat valid
//  in_data    in   DW   upstream payload
//  in_ready   out  1    block can accept this cycle
//  out_valid  out  1    downstream beat valid
//  out_data   out  DW   downstream payload (NOP_VAL when out_valid=0)
//  out_ready  in   1    downstream can accept
//  occ        out  2    entries held (0..2; max 1 when SKID=0)
//  flush_cnt  out  CW   valid beats discarded by flush, saturating
// BEHAVIOUR
//  - clr: state EMPTY, out_valid=0, out_data=NOP_VAL, occ=0, flush_cnt=0, in_ready=0 during clr.
//  - acc = in_valid & in_ready; emt = out_valid & out_ready & !stall.
//  - SKID=1: in_ready = (occ!=2) & !stall & !flush, computed from registered state only.
//  - SKID=0: in_ready = (!out_valid | out_ready) & !stall & !flush (combinational path allowed).
//  - States (SKID=1): EMPTY, ONE (main valid), FULL (main+skid valid).
//  - EMPTY: acc -> ONE, main<=in_data.
//  - ONE: acc&emt -> ONE, main<=in_data; acc&!emt -> FULL, skid<=in_data; !acc&emt -> EMPTY.
//  - FULL: emt -> ONE, main<=skid; otherwise hold.
//  - SKID=0: EMPTY/ONE only; acc loads main, emt without acc -> EMPTY.
//  - Latency: accepted beat visible on out_data the next cycle when the block was EMPTY.
//  - Ordering strictly FIFO; no beat duplicated or lost except by flush.
//  - out_data = main when out_valid, else NOP_VAL (bubble); out_valid = (state!=EMPTY).
//  - stall: contents, state, occ frozen; out_valid stays asserted if set, but no emit is counted.
//  - flush (priority flush > stall > handshake): next state EMPTY, out_data=NOP_VAL;
//    flush_cnt += occ + in_valid (beats dropped), saturating at 2^CW-1; no wrap.
//  - flush and clr both high: clr wins, flush_cnt=0.
//  - clr deasserted mid-stream: first accept allowed on first clk edge after release.
//  - Payload registers not reset when skid is unused; out_data masked by out_valid, so no X on out_data.
// TESTING
//  T1 reset: assert clr mid-stream with occ=2 -> immediately out_valid=0, out_data=NOP_VAL, occ=0, flush_cnt=0.
//  T2 pass-through: out_ready=1, stream in_data=0x1..0x8 back-to-back -> 0x1..0x8 out, 1-cycle latency, occ<=1.
//  T3 backpressure: out_ready=0, send 0xA,0xB,0xC -> occ=2, in_ready=0, 0xC held upstream; release -> A,B,C in order.
//  T4 flush: occ=2 plus in_valid=1 with flush -> next cycle occ=0, out_data=NOP_VAL, flush_cnt=3.
//  T5 stall: occ=1 holding 0x55, stall=1 for 3 cycles with out_ready=1 -> out_data=0x55 unchanged, in_ready=0, no emit.
//  T6 SKID=0 / saturation: same as T2 at full rate with in_ready tracking out_ready; CW=2, 5 flushes of 1 beat -> flush_cnt=3.

Source files
------------

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic pipeline stage: the upstream (in_*) side
// and the downstream (out_*) side of the register, seen from the stage itself.
interface pipe_stage_elastic_if #(
  parameter int DW = 64
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  // The pipeline stage register itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Whatever surrounds the stage: drives the upstream beat and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between two CPU stages. With SKID=1 a second
// (skid) entry lets in_ready come purely from registered state; with SKID=0
// it is a single entry whose ready passes through from downstream.
// Flush drops everything held plus the incoming beat and counts the dropped
// valid beats in a saturating counter; stall freezes the stage.
module pipe_stage_elastic #(
  parameter int            DW      = 64,
  parameter logic [DW-1:0] NOP_VAL = '0,
  parameter bit            SKID    = 1'b1,
  parameter int            CW      = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   flush,
  input  logic                   stall,
  pipe_stage_elastic_if.slave    bus,
  output logic [1:0]             occ,
  output logic [CW-1:0]          flush_cnt
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;

  logic          in_rdy;
  logic          out_vld;
  logic          acc;
  logic          emt;
  logic          load_main;
  logic          load_skid;
  logic          main_from_skid;
  logic [CW+1:0] cnt_sum;
  logic [CW-1:0] cnt_next;

  assign out_vld = (state != EMPTY);
  assign acc     = bus.in_valid & in_rdy;
  assign emt     = out_vld & bus.out_ready & ~stall;

  // Upstream ready: registered-only with a skid entry, pass-through otherwise.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the block leaves it unassigned and infers a latch.
    in_rdy = 1'b0;
    if (SKID) begin
      in_rdy = (state != FULL) & ~stall & ~flush & ~clr;
    end else begin
      in_rdy = (~out_vld | bus.out_ready) & ~stall & ~flush & ~clr;
    end
  end

  // Which payload register loads this cycle, and from where.
  always_comb begin
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: load_main = acc;
      ONE: begin
        load_main = acc & emt;
        load_skid = acc & ~emt & SKID;
      end
      FULL: begin
        load_main      = emt;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  // Dropped-beat count on flush: everything held plus the beat on the input, saturating.
  always_comb begin
    cnt_sum  = {2'b00, flush_cnt} + {{CW{1'b0}}, occ} + {{(CW+1){1'b0}}, bus.in_valid};
    cnt_next = (cnt_sum > {2'b00, {CW{1'b1}}}) ? {CW{1'b1}} : cnt_sum[CW-1:0];
  end

  // Occupancy FSM and flush counter; flush outranks stall and handshake.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (clr) begin
      state     <= EMPTY;
      flush_cnt <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      flush_cnt <= cnt_next;
    end else begin
      unique case (state)
        EMPTY: if (acc) state <= ONE;
        ONE: begin
          if (acc && !emt)      state <= SKID ? FULL : ONE;
          else if (!acc && emt) state <= EMPTY;
        end
        FULL:    if (emt) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Payload registers; contents only matter while the FSM marks them valid.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; the output mux below
    // substitutes NOP_VAL whenever no valid entry is held, so X never escapes.
    if (load_main) main_q <= main_from_skid ? skid_q : bus.in_data;
    if (load_skid) skid_q <= bus.in_data;
  end

  assign occ           = state;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_vld ? main_q : NOP_VAL;

endmodule
